intr_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller for the IR filter pipeline. Collects pulse or edge stimuli from up to NUM_CH processing blocks, such as frame-done or DMA-done, into per-channel pending bits. It applies a per-channel enable mask and drives a single registered interrupt line plus the index of the highest-priority active channel to the PS. Pending bits are cleared per channel by an acknowledge vector.

---
 rtl/intr_ctrl_if.sv | 33 +++
 rtl/intr_ctrl.sv | 94 +++++++++
 tb/tb_intr_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : intr_ctrl_if
// Brief  : Event/mask/ack and pending/interrupt bundle for intr_ctrl.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface intr_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TMR_W  = 16
);
    logic [NUM_CH-1:0] stimulus;
    logic [NUM_CH-1:0] edge_mode;
    logic [NUM_CH-1:0] intr_en;
    logic [NUM_CH-1:0] intr_ack;
    logic [TMR_W-1:0]  coal_thr;
    logic [NUM_CH-1:0] pending;
    logic              intr;
    logic [ID_W-1:0]   intr_id;

    modport master (
        output stimulus, edge_mode, intr_en, intr_ack, coal_thr,
        input  pending, intr, intr_id
    );

    modport slave (
        input  stimulus, edge_mode, intr_en, intr_ack, coal_thr,
        output pending, intr, intr_id
    );
endinterface

`default_nettype wire

// File: rtl/intr_ctrl.sv
//------------------------------------------------------------------------------
// Module : intr_ctrl
// Brief  : Multi-channel interrupt controller with pending bits, enable mask and
//          lowest-index priority. Define INTR_COALESCE_EN to add the coalescing timer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module intr_ctrl #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TMR_W  = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    intr_ctrl_if.slave bus
);

    logic [NUM_CH-1:0] r_stim_d;
    logic [NUM_CH-1:0] r_pending;
    logic              r_intr;
    logic [ID_W-1:0]   r_intr_id;
    logic [NUM_CH-1:0] w_event;
    logic [NUM_CH-1:0] w_active;
    logic              w_any;
    logic [ID_W-1:0]   w_low_id;

    assign w_event  = (bus.stimulus & ~r_stim_d & bus.edge_mode)
                    | (bus.stimulus & ~bus.edge_mode);
    assign w_active = r_pending & bus.intr_en;
    assign w_any    = |w_active;

    // Descending scan so the lowest set index is the last one written
    always_comb begin
        w_low_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_low_id = ID_W'(i);
            end
        end
    end

    // Ack has priority over a same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stim_d  <= '0;
            r_pending <= '0;
            r_intr_id <= '0;
        end else begin
            r_stim_d  <= bus.stimulus;
            r_pending <= (r_pending | w_event) & ~bus.intr_ack;
            if (w_any) begin
                r_intr_id <= w_low_id;
            end
        end
    end

`ifdef INTR_COALESCE_EN
    logic [TMR_W-1:0] r_timer;

    // Timer runs only while something is active and the line is still low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
            r_intr  <= 1'b0;
        end else begin
            if (!w_any) begin
                r_timer <= '0;
            end else if (!r_intr && (r_timer != {TMR_W{1'b1}})) begin
                r_timer <= r_timer + TMR_W'(1);
            end
            r_intr <= w_any & (r_intr | (r_timer == bus.coal_thr));
        end
    end
`else
    logic w_unused_coal_thr;
    assign w_unused_coal_thr = ^bus.coal_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intr <= 1'b0;
        end else begin
            r_intr <= w_any;
        end
    end
`endif

    assign bus.pending = r_pending;
    assign bus.intr    = r_intr;
    assign bus.intr_id = r_intr_id;

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_intr_ctrl
// Brief  : Directed and random stimulus for intr_ctrl against a cycle-level model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_intr_ctrl;
    localparam int NUM_CH = 4;
    localparam int TMR_W  = 16;

    logic clk;
    logic rst_n;

    intr_ctrl_if #(.NUM_CH(NUM_CH), .TMR_W(TMR_W)) bus ();

    intr_ctrl #(.NUM_CH(NUM_CH), .TMR_W(TMR_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit       m_pend [NUM_CH];
    bit       m_sd   [NUM_CH];
    bit       m_intr;
    int       m_id;
    int       m_wait;

    function automatic logic [NUM_CH-1:0] pend_vec();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0;
            m_sd[i]   = 0;
        end
        m_intr = 0;
        m_id   = 0;
        m_wait = 0;
    endtask

    // One rising clock edge of the controller, from the rules in plain terms
    task automatic model_edge();
        int  lowest;
        bit  any_act;
        bit  ev;
        lowest  = -1;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m_pend[i] && bus.intr_en[i]) lowest = i;
        any_act = (lowest >= 0);
`ifdef INTR_COALESCE_EN
        if (!any_act) begin
            m_intr = 0;
            m_wait = 0;
        end else if (!m_intr) begin
            if (m_wait >= int'(bus.coal_thr)) m_intr = 1;
            else m_wait++;
        end
`else
        m_intr = any_act;
`endif
        if (any_act) m_id = lowest;
        for (int i = 0; i < NUM_CH; i++) begin
            ev = bus.edge_mode[i] ? (bus.stimulus[i] && !m_sd[i]) : bus.stimulus[i];
            if (bus.intr_ack[i]) m_pend[i] = 0;
            else if (ev)         m_pend[i] = 1;
            m_sd[i] = bus.stimulus[i];
        end
    endtask

    task automatic check_all(input string tag);
        n_checks++;
        assert (bus.pending === pend_vec()) else begin
            n_fail++;
            $error("FAIL %s pending: got %h expected %h", tag, bus.pending, pend_vec());
        end
        n_checks++;
        assert (bus.intr === m_intr) else begin
            n_fail++;
            $error("FAIL %s intr: got %b expected %b", tag, bus.intr, m_intr);
        end
        n_checks++;
        assert (bus.intr_id === 2'(m_id)) else begin
            n_fail++;
            $error("FAIL %s intr_id: got %0d expected %0d", tag, bus.intr_id, m_id);
        end
    endtask

    task automatic check_const(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.stimulus  = 4'hF;
        bus.edge_mode = 4'h0;
        bus.intr_en   = 4'h0;
        bus.intr_ack  = 4'h0;
`ifdef INTR_COALESCE_EN
        bus.coal_thr  = 16'd5;
`else
        bus.coal_thr  = 16'd0;
`endif
        model_reset();

        // Reset held with all stimuli high
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check_const("reset_pending", 32'(bus.pending), 32'h0);
        bus.edge_mode = 4'hF;
        rst_n = 1'b1;
        tick("first_edge");
        check_const("first_edge_pending", 32'(bus.pending), 32'hF);

        bus.stimulus = 4'h0;
        bus.intr_ack = 4'hF;
        tick("clear_all");
        bus.intr_ack = 4'h0;
        ticks(2, "idle");

        // Edge mode, channel 2 held high
        bus.edge_mode = 4'h4;
        bus.intr_en   = 4'h4;
        bus.stimulus  = 4'h4;
        ticks(10, "edge_hold");
        bus.intr_ack  = 4'h4;
        tick("edge_ack");
        bus.intr_ack  = 4'h0;
        ticks(3, "edge_no_retrig");
        check_const("edge_no_retrig_pending", 32'(bus.pending), 32'h0);
        bus.stimulus  = 4'h0;
        tick("edge_release");

        // Level mode with masking
        bus.edge_mode = 4'h0;
        bus.intr_en   = 4'h0;
        bus.stimulus  = 4'h2;
        tick("lvl_pulse");
        bus.stimulus  = 4'h0;
        ticks(2, "lvl_masked");
        check_const("lvl_masked_pending", 32'(bus.pending), 32'h2);
        bus.intr_en   = 4'h2;
        ticks(8, "lvl_unmask");

        // Priority with partial acknowledge
        bus.stimulus  = 4'hA;
        bus.intr_en   = 4'hA;
        tick("prio_set");
        bus.stimulus  = 4'h0;
        ticks(8, "prio_both");
        check_const("prio_id1", 32'(bus.intr_id), 32'd1);
        bus.intr_ack  = 4'h2;
        tick("prio_ack1");
        bus.intr_ack  = 4'h0;
        ticks(2, "prio_ch3");
        check_const("prio_id3", 32'(bus.intr_id), 32'd3);
        bus.intr_ack  = 4'h8;
        tick("prio_ack3");
        bus.intr_ack  = 4'h0;
        ticks(2, "prio_done");

        // Ack and event collide on channel 0
        bus.intr_en   = 4'hF;
        bus.stimulus  = 4'h1;
        bus.intr_ack  = 4'h1;
        tick("collide");
        bus.stimulus  = 4'h0;
        bus.intr_ack  = 4'h0;
        ticks(3, "collide_after");
        check_const("collide_pending", 32'(bus.pending), 32'h0);

        // Event on channel 0, then one acked during the coalescing window
        bus.stimulus  = 4'h1;
        tick("coal_ev");
        bus.stimulus  = 4'h0;
        ticks(8, "coal_wait");
        bus.intr_ack  = 4'h1;
        tick("coal_ack");
        bus.intr_ack  = 4'h0;
        bus.stimulus  = 4'h1;
        tick("coal_ev2");
        bus.stimulus  = 4'h0;
        ticks(3, "coal_early");
        bus.intr_ack  = 4'h1;
        tick("coal_early_ack");
        bus.intr_ack  = 4'h0;
        ticks(8, "coal_never");

        // Asynchronous reset mid-operation, stimulus already high
        bus.edge_mode = 4'hF;
        bus.stimulus  = 4'h5;
        ticks(4, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        tick("post_async");
        check_const("post_async_pending", 32'(bus.pending), 32'h5);

        // Random phase
        bus.coal_thr = 16'($urandom_range(0, 4));
        for (int k = 0; k < 400; k++) begin
            bus.stimulus = 4'($urandom);
            if ($urandom_range(0, 7) == 0) bus.edge_mode = 4'($urandom);
            if ($urandom_range(0, 5) == 0) bus.intr_en   = 4'($urandom);
            bus.intr_ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
